// File: rtl/ram_port_arbiter.sv
// Four-port arbiter onto one synchronous RAM port with a two-cycle read return.
// Fixed priority (port 0 highest) unless ARB_ROUND_ROBIN_EN is defined.
module ram_port_arbiter #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [3:0]          req,
   input  logic [3:0]          wr_req,
   input  logic [4*ADDR_W-1:0] addr_req,
   input  logic [4*DATA_W-1:0] wdata_req,
   output logic [3:0]          gnt,
   output logic [3:0]          rvalid,
   output logic [DATA_W-1:0]   rdata,
   output logic                ram_cs,
   output logic                ram_wr,
   output logic [ADDR_W-1:0]   ram_addr,
   output logic [DATA_W-1:0]   ram_din,
   input  logic [DATA_W-1:0]   ram_dout
);

   logic [3:0] w_rot;
   logic [1:0] w_off;
   logic       w_hit;
   logic       w_any;
   logic [1:0] w_sel;
   logic [3:0] w_gnt;
   logic [3:0] r_rd_pend;  // one-hot owner of the read currently on the RAM bus

`ifdef ARB_ROUND_ROBIN_EN
   logic [1:0] r_ptr;
   logic [7:0] w_req2;
   logic [2:0] w_shift;

   // Rotate so that bit 0 is the port just after the last winner.
   assign w_req2  = {req, req};
   assign w_shift = {1'b0, r_ptr} + 3'd1;
   assign w_rot   = w_req2[w_shift +: 4];
   assign w_sel   = r_ptr + 2'd1 + w_off;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr <= 2'd3;
      end else if (w_any) begin
         r_ptr <= w_sel;
      end
   end
`else
   assign w_rot = req;
   assign w_sel = w_off;
`endif

   always_comb begin
      w_hit = |w_rot;
      w_off = 2'd0;
      if (w_rot[0])      w_off = 2'd0;
      else if (w_rot[1]) w_off = 2'd1;
      else if (w_rot[2]) w_off = 2'd2;
      else if (w_rot[3]) w_off = 2'd3;
   end

   assign w_any = w_hit & ~rst;
   assign w_gnt = w_any ? (4'b0001 << w_sel) : 4'b0000;
   assign gnt   = w_gnt;
   assign rdata = ram_dout;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ram_cs    <= 1'b0;
         ram_wr    <= 1'b0;
         ram_addr  <= '0;
         ram_din   <= '0;
         r_rd_pend <= '0;
         rvalid    <= '0;
      end else begin
         ram_cs <= w_any;
         ram_wr <= w_any & wr_req[w_sel];
         if (w_any) begin
            ram_addr <= addr_req[w_sel*ADDR_W +: ADDR_W];
            ram_din  <= wdata_req[w_sel*DATA_W +: DATA_W];
         end
         r_rd_pend <= (w_any && !wr_req[w_sel]) ? w_gnt : 4'b0000;
         rvalid    <= r_rd_pend;
      end
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: RAM model, per-cycle reference model
// of grants/commands/read returns, directed scenarios and randomized traffic.
module tb_ram_port_arbiter;
   localparam int AW = 10;
   localparam int DW = 8;
`ifdef ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [3:0]    req, wr_req;
   logic [4*AW-1:0] addr_req;
   logic [4*DW-1:0] wdata_req;
   logic [3:0]    gnt, rvalid;
   logic [DW-1:0] rdata;
   logic          ram_cs, ram_wr;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din, ram_dout;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst), .req(req), .wr_req(wr_req), .addr_req(addr_req),
      .wdata_req(wdata_req), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
      .ram_cs(ram_cs), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_din(ram_din),
      .ram_dout(ram_dout));

   // Synchronous RAM: data appears the cycle after a read command is sampled.
   logic [DW-1:0] mem [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (ram_cs) begin
         if (ram_wr) mem[ram_addr] <= ram_din;
         else        ram_dout <= mem[ram_addr];
      end
   end

   task automatic chk(string nm, longint act, longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic fail_now(string nm);
      checks++;
      errors++;
      $display("FAIL %s timed out t=%0t", nm, $time);
   endtask

   // Reference model state
   logic [DW-1:0] shadow [0:(1<<AW)-1];
   logic [3:0]    sched_rv [0:3];
   logic [DW-1:0] sched_rd [0:3];
   logic          m_cs = 1'b0, m_wr = 1'b0;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_din = '0;
   int            m_ptr = 3;
   int            cyc = 0;
   int            win, slot, idx;
   int            cs_cnt = 0;
   logic [3:0]    last_gnt = '0;

   logic [3:0]    gnt_vec_log[$];
   int            gnt_cyc_log[$];
   logic [3:0]    rv_vec_log[$];
   logic [DW-1:0] rv_data_log[$];
   int            rv_cyc_log[$];
   int            rd_addr_log[$];
   logic [3:0]    rd_port_log[$];

   initial for (int i = 0; i < 4; i++) sched_rv[i] = '0;

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_gnt", gnt, 0);
         chk("rst_rvalid", rvalid, 0);
         chk("rst_ram_cs", ram_cs, 0);
         chk("rst_ram_wr", ram_wr, 0);
         chk("rst_ram_addr", ram_addr, 0);
         chk("rst_ram_din", ram_din, 0);
         for (int i = 0; i < 4; i++) sched_rv[i] = '0;
         m_cs = 1'b0; m_wr = 1'b0; m_addr = '0; m_din = '0;
         m_ptr = 3;
         last_gnt = '0;
      end else begin
         slot = cyc % 4;
         chk("rvalid", rvalid, sched_rv[slot]);
         if (sched_rv[slot] != 0) chk("rdata", rdata, sched_rd[slot]);
         if (rvalid != 0) begin
            rv_vec_log.push_back(rvalid);
            rv_data_log.push_back(rdata);
            rv_cyc_log.push_back(cyc);
         end
         sched_rv[slot] = '0;
         if (ram_cs) cs_cnt++;
         chk("ram_cs", ram_cs, m_cs);
         chk("ram_wr", ram_wr, m_wr);
         chk("ram_addr", ram_addr, m_addr);
         chk("ram_din", ram_din, m_din);
         win = -1;
         for (int k = 0; k < 4; k++) begin
            idx = RR ? (m_ptr + 1 + k) % 4 : k;
            if (win < 0 && req[idx]) win = idx;
         end
         chk("gnt", gnt, (win < 0) ? 0 : (1 << win));
         last_gnt = gnt;
         if (gnt != 0) begin
            gnt_vec_log.push_back(gnt);
            gnt_cyc_log.push_back(cyc);
         end
         if (win >= 0) begin
            m_cs   = 1'b1;
            m_wr   = wr_req[win];
            m_addr = addr_req[win*AW +: AW];
            m_din  = wdata_req[win*DW +: DW];
            m_ptr  = win;
            if (m_wr) begin
               shadow[m_addr] = m_din;
            end else begin
               sched_rv[(cyc + 2) % 4] = 4'b0001 << win;
               sched_rd[(cyc + 2) % 4] = shadow[m_addr];
               rd_addr_log.push_back(int'(m_addr));
               rd_port_log.push_back(4'b0001 << win);
            end
         end else begin
            m_cs = 1'b0;
            m_wr = 1'b0;
         end
      end
      cyc++;
   end

   task automatic clear_logs();
      gnt_vec_log.delete(); gnt_cyc_log.delete();
      rv_vec_log.delete(); rv_data_log.delete(); rv_cyc_log.delete();
      rd_addr_log.delete(); rd_port_log.delete();
      cs_cnt = 0;
   endtask

   task automatic set_port(int p, bit w, int a, int d);
      req[p] = 1'b1;
      wr_req[p] = w;
      addr_req[p*AW +: AW] = AW'(a);
      wdata_req[p*DW +: DW] = DW'(d);
   endtask

   task automatic idle(int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // Called at posedge+1; returns at posedge+1 right after acceptance.
   task automatic do_txn(int p, bit w, int a, int d);
      int n = 0;
      set_port(p, w, a, d);
      @(negedge clk);
      while (!gnt[p] && n < 8) begin n++; @(negedge clk); end
      if (n >= 8) fail_now("txn_gnt");
      @(posedge clk); #1;
      req[p] = 1'b0;
   endtask

   // Hold all pending requests, dropping each once accepted; port 0 may stay for extra grants.
   task automatic drain(int hold0, int max_cyc);
      int n = 0;
      int h = hold0;
      while (req != 0 && n < max_cyc) begin
         @(posedge clk); #1; n++;
         for (int i = 0; i < 4; i++) begin
            if (last_gnt[i]) begin
               if (i == 0 && h > 0) h--;
               else req[i] = 1'b0;
            end
         end
      end
      if (req != 0) fail_now("drain");
   endtask

   task automatic rand_phase(int n_ops, bit allow_wr, int amax);
      int issued = 0;
      int n = 0;
      while ((issued < n_ops || req != 0) && n < 4000) begin
         for (int p = 0; p < 4; p++) begin
            if (req[p] && last_gnt[p]) req[p] = 1'b0;
            if (!req[p] && issued < n_ops && $urandom_range(0, 2) != 0) begin
               set_port(p, allow_wr ? 1'($urandom_range(0, 1)) : 1'b0,
                        $urandom_range(0, amax), $urandom_range(0, 255));
               issued++;
            end
         end
         @(posedge clk); #1; n++;
      end
      if (n >= 4000) fail_now("rand_phase");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0]    exp_g [$];
      logic [DW-1:0] exp_d [$];
      int a, n;
      rst = 1'b1; req = '0; wr_req = '0; addr_req = '0; wdata_req = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      idle(2);

      // Single write then read on port 1
      clear_logs();
      do_txn(1, 1'b1, 5, 8'hA5);
      do_txn(1, 1'b0, 5, 0);
      idle(4);
      chk("t1_rv_count", rv_vec_log.size(), 1);
      chk("t1_rvalid", rv_vec_log[0], 4'b0010);
      chk("t1_rdata", rv_data_log[0], 8'hA5);
      chk("t1_gnt", gnt_vec_log[1], 4'b0010);
      chk("t1_latency", rv_cyc_log[0] - gnt_cyc_log[1], 2);

      // All ports contending for reads of 10..13 preloaded with 1..4
      for (int i = 0; i < 4; i++) do_txn(3, 1'b1, 10 + i, i + 1);
      idle(1);
      clear_logs();
      for (int i = 0; i < 4; i++) set_port(i, 1'b0, 10 + i, 0);
`ifdef ARB_ROUND_ROBIN_EN
      drain(0, 20);
      exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
      exp_d = '{8'd1, 8'd2, 8'd3, 8'd4};
`else
      drain(2, 20);
      exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
      exp_d = '{8'd1, 8'd1, 8'd1, 8'd2, 8'd3, 8'd4};
`endif
      idle(4);
      chk("t2_gnt_count", gnt_vec_log.size(), exp_g.size());
      chk("t2_rv_count", rv_vec_log.size(), exp_g.size());
      for (int i = 0; i < exp_g.size(); i++) begin
         chk("t2_gnt_order", gnt_vec_log[i], exp_g[i]);
         chk("t2_rv_order", rv_vec_log[i], exp_g[i]);
         chk("t2_rdata", rv_data_log[i], exp_d[i]);
      end

      // Write addr 1023 on port 2, read it back on port 3 the next cycle
      clear_logs();
      set_port(2, 1'b1, 1023, 8'h3C);
      set_port(3, 1'b0, 1023, 0);
      drain(0, 10);
      idle(4);
      chk("t3_gnt0", gnt_vec_log[0], 4'b0100);
      chk("t3_gnt1", gnt_vec_log[1], 4'b1000);
      chk("t3_b2b", gnt_cyc_log[1] - gnt_cyc_log[0], 1);
      chk("t3_rv_count", rv_vec_log.size(), 1);
      chk("t3_rvalid", rv_vec_log[0], 4'b1000);
      chk("t3_rdata", rv_data_log[0], 8'h3C);

      // Reset pulsed the cycle after a read is accepted
      clear_logs();
      do_txn(0, 1'b0, 5, 0);
      #1 rst = 1'b1;
      #1 chk("t4_cs_in_rst", ram_cs, 0);
      @(negedge clk);
      #3 rst = 1'b0;
      idle(4);
      chk("t4_gnt_count", gnt_vec_log.size(), 1);
      chk("t4_rv_count", rv_vec_log.size(), 0);

      // Idle
      clear_logs();
      idle(10);
      chk("t5_gnt_count", gnt_vec_log.size(), 0);
      chk("t5_rv_count", rv_vec_log.size(), 0);
      chk("t5_cs_count", cs_cnt, 0);

      // Full sweep of writes through port 0, back to back
      a = 0; n = 0;
      set_port(0, 1'b1, 0, 0);
      while (a < 1024 && n < 1200) begin
         @(posedge clk); #1; n++;
         if (last_gnt[0]) begin
            a++;
            if (a < 1024) set_port(0, 1'b1, a, (2 * a) % 256);
            else req[0] = 1'b0;
         end
      end
      if (a < 1024) fail_now("sweep");
      idle(3);

      // Random reads across ports, each checked against the sweep pattern
      clear_logs();
      rand_phase(20, 1'b0, 1023);
      idle(4);
      chk("t6_rv_count", rv_vec_log.size(), 20);
      for (int i = 0; i < rv_vec_log.size() && i < rd_addr_log.size(); i++) begin
         chk("t6_rdata", rv_data_log[i], (2 * rd_addr_log[i]) % 256);
         chk("t6_rvalid", rv_vec_log[i], rd_port_log[i]);
      end

      // Mixed random reads and writes over a small address range
      clear_logs();
      rand_phase(150, 1'b1, 15);
      idle(4);
      chk("t7_rv_count", rv_vec_log.size(), rd_addr_log.size());

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have these parameters: ADDR_W, default 10, RAM address width; DATA_W, default 8, RAM data width; port count fixed at 4.
REQ-002 SHALL have a single clock and reset: clk input 1, rising-edge clock; reset is asynchronous and active-high.
REQ-003 SHALL have the reset port: rst input 1, asynchronous active-high reset.
REQ-004 SHALL have the requester ports: req input 4, per-port request; wr_req input 4, per-port 1=write, 0=read; addr_req input 4*ADDR_W, port i at [i*ADDR_W +: ADDR_W]; wdata_req input 4*DATA_W, port i at [i*DATA_W +: DATA_W].
REQ-005 SHALL have the response ports: gnt output 4, one-hot accept strobe; rvalid output 4, one-hot read-data valid; rdata output DATA_W, read data shared by all ports.
REQ-006 SHALL have the RAM-side ports: ram_cs output 1, chip select; ram_wr output 1, write enable; ram_addr output ADDR_W; ram_din output DATA_W; ram_dout input DATA_W, RAM data registered one cycle after a read command is sampled.

Function
REQ-007 SHALL accept at most one request per cycle; gnt is combinational from req and the priority state, and at most one bit is high.
REQ-008 SHALL treat a request as accepted at the rising edge ending a cycle with gnt[i]=1; the requester holds req, wr_req, addr_req and wdata_req stable until then.
REQ-009 SHALL register the accepted command onto ram_cs=1, ram_wr, ram_addr and ram_din for exactly the following cycle (N+1).
REQ-010 SHALL drive ram_cs=0 and ram_wr=0 in any cycle after a cycle with no grant; ram_addr and ram_din hold their last values.
REQ-011 SHALL, for a read accepted at end of cycle N, assert rvalid[i] for exactly cycle N+2 with rdata=ram_dout; read latency is 2 cycles from acceptance.
REQ-012 SHALL never assert rvalid for writes.
REQ-013 SHALL pass rdata through from ram_dout; rdata is meaningful only while some rvalid bit is 1.
REQ-014 SHALL sustain back-to-back accepts every cycle, with up to two reads in flight.
REQ-015 SHALL issue commands in acceptance order, so a write followed by a read to the same address returns the newly written data.
REQ-016 SHALL pass addresses unmodified, with no wrap or range check; all 2^ADDR_W addresses are valid.
REQ-017 SHALL keep gnt at 0 when req=0.

Reset
REQ-018 SHALL, while rst=1, force gnt=0, rvalid=0, ram_cs=0, ram_wr=0, ram_addr=0, ram_din=0 and the priority pointer to 3.
REQ-019 SHALL discard any commands in flight when rst is asserted mid-operation, so no rvalid appears after reset releases.
REQ-020 SHALL evaluate grants from the first clock edge after rst deasserts.

Configuration
REQ-021 SHALL use the macro ARB_ROUND_ROBIN_EN to select the arbitration policy.
REQ-022 SHALL, when ARB_ROUND_ROBIN_EN is defined, use round-robin: search starts at pointer+1 mod 4, and the pointer updates to the granted index on each accept.
REQ-023 SHALL, when ARB_ROUND_ROBIN_EN is undefined, use fixed priority (port 0 highest, port 3 lowest); the pointer is not implemented.

Verification
REQ-024 SHALL cover single write then read: port 1 writes addr 5 data 8'hA5 and is accepted; port 1 then reads addr 5 -> rvalid=4'b0010 two cycles after the read gnt, rdata=8'hA5.
REQ-025 SHALL cover all ports contending: req=4'b1111, held, with reads to addrs 10/11/12/13 preloaded 1/2/3/4 -> round-robin gnt order 0,1,2,3 on consecutive cycles, rvalid in the same order with rdata 1,2,3,4; fixed priority grants port 0 continuously until it drops req.
REQ-026 SHALL cover back-to-back same-address access: port 2 writes addr 1023 data 8'h3C, and port 3 reads addr 1023 in the next cycle -> rvalid=4'b1000, rdata=8'h3C.
REQ-027 SHALL cover reset mid-read: read accepted at end of cycle N, rst pulsed during cycle N+1 -> rvalid stays 0 through N+3, and ram_cs=0 while rst=1.
REQ-028 SHALL cover idle: req=0 for 10 cycles -> gnt=0, rvalid=0, ram_cs=0 every cycle.
REQ-029 SHALL cover a full sweep: every address 0..1023 written with (2*addr)%256 through port 0, then 20 random reads across ports -> each rdata equals (2*addr)%256 at the correct rvalid bit.
